// File: rtl/hartslag_generator.sv
`default_nettype none
// ============================================================================
// Module   : hartslag_generator
// Purpose  : Heartbeat pulse train from a programmed BPM rate; the period is
//            derived on-chip by a 32-step serial restoring divider.
// Revision : 1.0
// ============================================================================
module hartslag_generator #(
    parameter logic [31:0] CLK_HZ       = 32'd50000000,
    parameter logic [31:0] PULSE_CYCLES = 32'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bpm,
    input  logic        start,
    input  logic        stop,
    output logic        uit,
    output logic        busy,
    output logic        actief,
    output logic [31:0] periode,
    output logic [7:0]  slagen,
    output logic        fout
);

    localparam logic [31:0] c_DIVIDEND = CLK_HZ * 32'd60;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  bpm_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [4:0]  idx_q;
    logic [31:0] cnt_q;
    logic [31:0] periode_q;
    logic [7:0]  slagen_q;
    logic        uit_q;
    logic        busy_q;
    logic        actief_q;
    logic        fout_q;

    logic [4:0]  w_bit_idx;
    logic [32:0] w_rem_shift;
    logic [32:0] w_divisor;
    logic        w_sub_ok;
    logic [32:0] rem_d;
    logic [31:0] quot_d;
    logic [31:0] w_last;
    logic [31:0] w_high;
    logic        uit_d;

    // Dividend bits are consumed MSB first, one per DIVIDE cycle.
    assign w_bit_idx   = 5'd31 - idx_q;
    assign w_rem_shift = {rem_q, c_DIVIDEND[w_bit_idx]};
    assign w_divisor   = {25'd0, bpm_q};
    assign w_sub_ok    = (w_rem_shift >= w_divisor);
    assign rem_d       = w_sub_ok ? (w_rem_shift - w_divisor) : w_rem_shift;
    assign quot_d      = {quot_q[30:0], w_sub_ok};

    // High time is clamped so at least one low cycle remains per period.
    assign w_last = (periode_q == 32'd0) ? 32'd0 : (periode_q - 32'd1);
    assign w_high = (PULSE_CYCLES < w_last) ? PULSE_CYCLES : w_last;
    assign uit_d  = (cnt_q < w_high);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bpm_q     <= 8'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            idx_q     <= 5'd0;
            cnt_q     <= 32'd0;
            periode_q <= 32'd0;
            slagen_q  <= 8'd0;
            uit_q     <= 1'b0;
            busy_q    <= 1'b0;
            actief_q  <= 1'b0;
            fout_q    <= 1'b0;
        end else if (stop) begin
            state_q  <= S_IDLE;
            uit_q    <= 1'b0;
            busy_q   <= 1'b0;
            actief_q <= 1'b0;
        end else if (start) begin
            uit_q    <= 1'b0;
            actief_q <= 1'b0;
            if (bpm == 8'd0) begin
                fout_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                fout_q   <= 1'b0;
                slagen_q <= 8'd0;
                bpm_q    <= bpm;
                rem_q    <= 32'd0;
                quot_q   <= 32'd0;
                idx_q    <= 5'd0;
                busy_q   <= 1'b1;
                state_q  <= S_DIVIDE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    uit_q <= 1'b0;
                end
                S_DIVIDE: begin
                    rem_q  <= rem_d[31:0];
                    quot_q <= quot_d;
                    idx_q  <= idx_q + 5'd1;
                    if (idx_q == 5'd31) begin
                        periode_q <= quot_d;
                        cnt_q     <= 32'd0;
                        busy_q    <= 1'b0;
                        actief_q  <= 1'b1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    uit_q <= uit_d;
                    cnt_q <= (cnt_q >= w_last) ? 32'd0 : (cnt_q + 32'd1);
                    if (uit_d && !uit_q) begin
                        slagen_q <= slagen_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uit     = uit_q;
    assign busy    = busy_q;
    assign actief  = actief_q;
    assign periode = periode_q;
    assign slagen  = slagen_q;
    assign fout    = fout_q;

endmodule
`default_nettype wire

// File: tb/tb_hartslag_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hartslag_generator
// Purpose  : Self-checking bench for hartslag_generator (CLK_HZ=100, two pulse
//            widths side by side) against a closed-form timing model.
// Revision : 1.0
// ============================================================================
module tb_hartslag_generator;

    localparam int c_DIV = 6000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  bpm = 8'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic        uit_a, busy_a, actief_a, fout_a;
    logic [31:0] periode_a;
    logic [7:0]  slagen_a;
    logic        uit_b, busy_b, actief_b, fout_b;
    logic [31:0] periode_b;
    logic [7:0]  slagen_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hartslag_generator #(.CLK_HZ(32'd100), .PULSE_CYCLES(32'd10)) dut_a (
        .clk(clk), .reset(reset), .bpm(bpm), .start(start), .stop(stop),
        .uit(uit_a), .busy(busy_a), .actief(actief_a), .periode(periode_a),
        .slagen(slagen_a), .fout(fout_a)
    );

    hartslag_generator #(.CLK_HZ(32'd100), .PULSE_CYCLES(32'd50)) dut_b (
        .clk(clk), .reset(reset), .bpm(bpm), .start(start), .stop(stop),
        .uit(uit_b), .busy(busy_b), .actief(actief_b), .periode(periode_b),
        .slagen(slagen_b), .fout(fout_b)
    );

    // Model: time since the accepted start edge; everything else follows
    // from the period arithmetic.
    logic       m_act = 1'b0;
    int         m_t = 0;
    int         m_bpm = 0;
    int         m_per = 0;
    logic [7:0] m_sl = 8'd0;
    logic       m_fout = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            m_bpm  <= 0;
            m_per  <= 0;
            m_sl   <= 8'd0;
            m_fout <= 1'b0;
        end else if (stop) begin
            m_act <= 1'b0;
        end else if (start) begin
            if (bpm == 8'd0) begin
                m_fout <= 1'b1;
                m_act  <= 1'b0;
            end else begin
                m_fout <= 1'b0;
                m_act  <= 1'b1;
                m_t    <= 0;
                m_bpm  <= int'(bpm);
                m_sl   <= 8'd0;
            end
        end else if (m_act) begin
            m_t <= m_t + 1;
            if (m_t + 1 == 32) m_per <= c_DIV / m_bpm;
            if (m_t + 1 >= 33 && m_per > 1) m_sl <= 8'(((m_t + 1 - 33) / m_per + 1) % 256);
        end
    end

    function automatic logic [63:0] model_vec(input int p);
        int   h;
        logic u;
        h = (m_per <= 0) ? 0 : ((p < m_per - 1) ? p : m_per - 1);
        u = m_act && (m_t >= 33) && (m_per > 0) && (((m_t - 33) % m_per) < h);
        return {20'd0, u, (m_act && m_t < 32), (m_act && m_t >= 32), 32'(m_per), m_sl, m_fout};
    endfunction

    function automatic logic [63:0] vec_a();
        return {20'd0, uit_a, busy_a, actief_a, periode_a, slagen_a, fout_a};
    endfunction

    function automatic logic [63:0] vec_b();
        return {20'd0, uit_b, busy_b, actief_b, periode_b, slagen_b, fout_b};
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp("model_a", vec_a(), model_vec(10));
        cmp("model_b", vec_b(), model_vec(50));
    endtask

    task automatic pulse_start(input logic [7:0] b);
        bpm = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic cur(input bit sel);
        return sel ? uit_b : uit_a;
    endfunction

    task automatic measure(input bit sel, output int hi, output int lo);
        int guard;
        hi = 0; lo = 0; guard = 0;
        while (cur(sel) !== 1'b0 && guard < 20000) begin tick(); guard++; end
        while (cur(sel) !== 1'b1 && guard < 20000) begin tick(); guard++; end
        while (cur(sel) === 1'b1 && guard < 20000) begin hi++; tick(); guard++; end
        while (cur(sel) === 1'b0 && guard < 20000) begin lo++; tick(); guard++; end
        if (guard >= 20000) begin
            n_checks++;
            n_fail++;
            $display("FAIL measure_timeout sel=%0d hi=%0d lo=%0d", sel, hi, lo);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        int         per;
        int         hi10;
        int         hi50;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int hi, lo;
        vecs[0] = '{8'd60,  100,  10, 50};
        vecs[1] = '{8'd7,   857,  10, 50};
        vecs[2] = '{8'd255, 23,   10, 22};
        vecs[3] = '{8'd120, 50,   10, 49};
        vecs[4] = '{8'd200, 30,   10, 29};
        vecs[5] = '{8'd1,   6000, 10, 50};

        repeat (3) tick();
        cmp("reset_a", vec_a(), 64'd0);
        cmp("reset_b", vec_b(), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // First-beat latency and slagen count at bpm=60.
        pulse_start(8'd60);
        cmp("busy_t0", 64'(busy_a), 64'd1);
        repeat (31) tick();
        cmp("busy_t31", 64'(busy_a), 64'd1);
        tick();
        cmp("busy_t32", 64'(busy_a), 64'd0);
        cmp("actief_t32", 64'(actief_a), 64'd1);
        cmp("periode_60", 64'(periode_a), 64'd100);
        cmp("uit_t32", 64'(uit_a), 64'd0);
        tick();
        cmp("uit_t33", 64'(uit_a), 64'd1);
        cmp("slagen_t33", 64'(slagen_a), 64'd1);
        repeat (199) tick();
        cmp("slagen_t232", 64'(slagen_a), 64'd2);
        tick();
        cmp("slagen_t233", 64'(slagen_a), 64'd3);

        for (int i = 0; i < 6; i++) begin
            pulse_start(vecs[i].b);
            repeat (33) tick();
            cmp("vec_periode", 64'(periode_a), 64'(vecs[i].per));
            cmp("vec_periode_b", 64'(periode_b), 64'(vecs[i].per));
            measure(1'b0, hi, lo);
            cmp("vec_hi10", 64'(hi), 64'(vecs[i].hi10));
            cmp("vec_lo10", 64'(lo), 64'(vecs[i].per - vecs[i].hi10));
            measure(1'b1, hi, lo);
            cmp("vec_hi50", 64'(hi), 64'(vecs[i].hi50));
            cmp("vec_lo50", 64'(lo), 64'(vecs[i].per - vecs[i].hi50));
        end

        // Zero-rate start flags the error and halts; a valid start clears it.
        pulse_start(8'd0);
        cmp("fout_set", 64'(fout_a), 64'd1);
        cmp("fout_actief", 64'(actief_a), 64'd0);
        cmp("fout_periode", 64'(periode_a), 64'd6000);
        repeat (10) tick();
        cmp("fout_uit", 64'(uit_a), 64'd0);
        pulse_start(8'd60);
        cmp("fout_clr", 64'(fout_a), 64'd0);
        repeat (60) tick();

        // Restart mid-run, then stop and start together.
        pulse_start(8'd120);
        cmp("restart_busy", 64'(busy_a), 64'd1);
        cmp("restart_slagen", 64'(slagen_a), 64'd0);
        cmp("restart_uit", 64'(uit_a), 64'd0);
        repeat (32) tick();
        cmp("restart_periode", 64'(periode_a), 64'd50);
        repeat (70) tick();
        stop = 1'b1;
        pulse_start(8'd60);
        stop = 1'b0;
        cmp("stopstart_actief", 64'(actief_a), 64'd0);
        cmp("stopstart_busy", 64'(busy_a), 64'd0);
        cmp("stopstart_periode", 64'(periode_a), 64'd50);
        repeat (5) tick();

        // Asynchronous reset during DIVIDE and during a high phase.
        pulse_start(8'd60);
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        cmp("areset_div_a", vec_a(), 64'd0);
        cmp("areset_div_b", vec_b(), 64'd0);
        tick();
        reset = 1'b1;
        repeat (50) tick();
        cmp("post_reset_idle", {62'd0, actief_a, uit_a}, 64'd0);
        pulse_start(8'd60);
        repeat (34) tick();
        cmp("high_before_reset", 64'(uit_a), 64'd1);
        #2 reset = 1'b0;
        #1;
        cmp("areset_run_a", vec_a(), 64'd0);
        cmp("areset_run_b", vec_b(), 64'd0);
        tick();
        reset = 1'b1;
        repeat (5) tick();

        // slagen wraps 255 -> 0 at the fastest rate.
        pulse_start(8'd255);
        repeat (5897) tick();
        cmp("slagen_255", 64'(slagen_a), 64'd255);
        tick();
        cmp("slagen_wrap", 64'(slagen_a), 64'd0);

        // Random start/stop/bpm traffic checked every cycle by the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            start = (r < 3) || (r == 100);
            stop  = (r >= 198) || (r == 100);
            bpm   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            tick();
        end
        start = 1'b0;
        stop = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
